// File: rtl/instr_decode_queue.sv
// Fetch-to-decode instruction queue with push-time pre-decode
// (control transfer, eret) and per-word branch-delay-slot flag.
module instr_decode_queue #(
    parameter int  DEPTH = 4,
    parameter int  EXC_W = 5,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    input  logic [EXC_W-1:0] in_exc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [EXC_W-1:0] out_exc,
    output logic             out_bd,
    output logic             out_cti,
    input  logic             flush,
    input  logic             flush_keep_ds,
    output logic [CNT_W-1:0] count
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [31:0]      r_pc    [DEPTH];
    logic [31:0]      r_instr [DEPTH];
    logic [EXC_W-1:0] r_exc   [DEPTH];
    logic             r_bd    [DEPTH];
    logic             r_cti   [DEPTH];

    logic [ADDR_W-1:0] r_head;
    logic [ADDR_W-1:0] r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_last_cti;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_wr;
    logic [5:0]        w_op;
    logic [4:0]        w_rt;
    logic [5:0]        w_func;
    logic              w_cti;
    logic              w_eret;
    logic [ADDR_W-1:0] w_head_nx;
    logic [CNT_W-1:0]  w_rem;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign in_ready  = !w_full || out_ready;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign count     = r_count;

    assign w_op   = in_instr[31:26];
    assign w_rt   = in_instr[20:16];
    assign w_func = in_instr[5:0];

    assign w_cti = (w_op == 6'b000100) || (w_op == 6'b000101)
                || (w_op == 6'b000110) || (w_op == 6'b000111)
                || (w_op == 6'b000010) || (w_op == 6'b000011)
                || (w_op == 6'b000001
                    && (w_rt == 5'b00000 || w_rt == 5'b00001))
                || (w_op == 6'b000000
                    && (w_func == 6'b001000 || w_func == 6'b001001));
    assign w_eret = (w_op == 6'b010000) && in_instr[25];

    assign w_head_nx = r_head + ADDR_W'(w_pop);
    assign w_rem     = r_count - CNT_W'(w_pop);

    // A push survives a flush only as the delay slot of an emptied queue
    assign w_wr = w_push
               && (!flush || (flush_keep_ds && w_rem == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_last_cti <= 1'b0;
        end else if (!flush) begin
            r_head  <= w_head_nx;
            r_tail  <= r_tail + ADDR_W'(w_push);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push)
                r_last_cti <= w_cti && !w_eret;
        end else if (!flush_keep_ds) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_last_cti <= 1'b0;
        end else if (w_rem != '0) begin
            r_head     <= w_head_nx;
            r_tail     <= w_head_nx + ADDR_W'(1);
            r_count    <= CNT_W'(1);
            r_last_cti <= 1'b0;
        end else if (w_push) begin
            r_head     <= w_head_nx;
            r_tail     <= r_tail + ADDR_W'(1);
            r_count    <= CNT_W'(1);
            r_last_cti <= 1'b0;
        end else begin
            // Branch popped alone: its delay slot is still to come
            r_head     <= w_head_nx;
            r_tail     <= r_tail;
            r_count    <= '0;
            r_last_cti <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && !reset) begin
            r_pc[r_tail]    <= in_pc;
            r_instr[r_tail] <= in_instr;
            r_exc[r_tail]   <= in_exc;
            r_bd[r_tail]    <= r_last_cti;
            r_cti[r_tail]   <= w_cti;
        end
    end

    assign out_pc    = w_empty ? 32'd0 : r_pc[r_head];
    assign out_instr = w_empty ? 32'd0 : r_instr[r_head];
    assign out_exc   = w_empty ? '0 : r_exc[r_head];
    assign out_bd    = w_empty ? 1'b0 : r_bd[r_head];
    assign out_cti   = w_empty ? 1'b0 : r_cti[r_head];

endmodule

// File: tb/tb_instr_decode_queue.sv
// Scoreboard bench: directed scenarios then random traffic,
// checked against a queue-based model of the instruction buffer.
module tb_instr_decode_queue;

    localparam int DEPTH = 4;
    localparam int EXC_W = 5;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_pc = '0;
    logic [31:0]      in_instr = '0;
    logic [EXC_W-1:0] in_exc = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic [EXC_W-1:0] out_exc;
    logic             out_bd;
    logic             out_cti;
    logic             flush = 1'b0;
    logic             flush_keep_ds = 1'b0;
    logic [CNT_W-1:0] count;

    instr_decode_queue #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_exc(in_exc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc),
        .out_bd(out_bd), .out_cti(out_cti),
        .flush(flush), .flush_keep_ds(flush_keep_ds),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [EXC_W-1:0] exc;
        bit               bd;
        bit               cti;
    } ent_t;

    ent_t q[$];
    bit   m_last = 1'b0;
    bit   chk_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] ADDU = 32'h0043_0821;
    localparam logic [31:0] BEQ  = 32'h1000_0003;
    localparam logic [31:0] ERET = 32'h4200_0018;
    localparam logic [31:0] JR   = 32'h03e0_0008;

    function automatic bit m_cti(logic [31:0] i);
        logic [5:0] op;
        op = i[31:26];
        return (op inside {6'h04, 6'h05, 6'h06, 6'h07, 6'h02, 6'h03})
            || (op == 6'h01 && i[20:16] inside {5'd0, 5'd1})
            || (op == 6'h00 && i[5:0] inside {6'h08, 6'h09});
    endfunction

    function automatic bit m_eret(logic [31:0] i);
        return i[31:26] == 6'h10 && i[25];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Model update for the edge that samples the current inputs
    task automatic model_edge();
        bit   rdy, push, pop;
        ent_t e;
        if (reset) begin
            q.delete();
            m_last = 1'b0;
            return;
        end
        rdy  = (q.size() < DEPTH) || out_ready;
        push = in_valid && rdy;
        pop  = (q.size() != 0) && out_ready;
        if (pop) void'(q.pop_front());
        e.pc    = in_pc;
        e.instr = in_instr;
        e.exc   = in_exc;
        e.bd    = m_last;
        e.cti   = m_cti(in_instr);
        if (!flush) begin
            if (push) begin
                q.push_back(e);
                m_last = e.cti && !m_eret(in_instr);
            end
        end else if (!flush_keep_ds) begin
            q.delete();
            m_last = 1'b0;
        end else if (q.size() >= 1) begin
            while (q.size() > 1) void'(q.pop_back());
            m_last = 1'b0;
        end else if (push) begin
            q.push_back(e);
            m_last = 1'b0;
        end else begin
            m_last = 1'b1;
        end
    endtask

    task automatic cycle(bit rst, bit v, logic [31:0] pc,
                         logic [31:0] ins, logic [4:0] exc,
                         bit ordy, bit fl, bit keep);
        reset         = rst;
        in_valid      = v;
        in_pc         = pc;
        in_instr      = ins;
        in_exc        = exc;
        out_ready     = ordy;
        flush         = fl;
        flush_keep_ds = keep;
        @(posedge clk);
        model_edge();
        chk_en = 1'b1;
        #2;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 32'(count), 32'(q.size()));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready),
                32'((q.size() < DEPTH) || out_ready));
            if (q.size() != 0) begin
                chk("out_pc", out_pc, q[0].pc);
                chk("out_instr", out_instr, q[0].instr);
                chk("out_exc", 32'(out_exc), 32'(q[0].exc));
                chk("out_bd", 32'(out_bd), 32'(q[0].bd));
                chk("out_cti", 32'(out_cti), 32'(q[0].cti));
            end else begin
                chk("empty_pc", out_pc, 32'd0);
                chk("empty_instr", out_instr, 32'd0);
                chk("empty_flags", {out_exc, out_bd, out_cti}, 32'd0);
            end
        end
    end

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: return BEQ;
            1: return {6'h05, r[25:0]};
            2: return {6'h02, r[25:0]};
            3: return {6'h01, r[25:21], 4'b0000, r[16], r[15:0]};
            4: return {6'h01, r[25:21], 5'b00010, r[15:0]};
            5: return ERET;
            6: return {6'h10, 1'b0, r[24:0]};
            7: return {6'h00, r[25:6], 5'b00100, r[0]};
            8: return ADDU;
            default: return r;
        endcase
    endfunction

    initial begin
        logic [31:0] pc;
        cycle(1, 0, 0, NOP, 0, 0, 0, 0);
        cycle(1, 0, 0, NOP, 0, 0, 0, 0);
        // fill to full, then hold in_valid while blocked
        for (int i = 0; i < 4; i++)
            cycle(0, 1, 32'h3000 + 32'(4 * i), NOP, 0, 0, 0, 0);
        cycle(0, 1, 32'h3010, NOP, 0, 0, 0, 0);
        // streaming at full, head wraps
        for (int i = 0; i < 8; i++)
            cycle(0, 1, 32'h3010 + 32'(4 * i), NOP, 0, 1, 0, 0);
        cycle(1, 0, 0, NOP, 0, 0, 0, 0);
        // delay-slot flagging
        cycle(0, 1, 32'h3000, BEQ, 0, 0, 0, 0);
        cycle(0, 1, 32'h3004, ADDU, 0, 0, 0, 0);
        cycle(0, 1, 32'h3008, ADDU, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, NOP, 0, 1, 0, 0);
        // flush keeping delay slot, then flush dropping all
        cycle(0, 1, 32'h3000, BEQ, 0, 0, 0, 0);
        cycle(0, 1, 32'h3004, ADDU, 0, 0, 0, 0);
        cycle(0, 1, 32'h3008, ADDU, 0, 0, 0, 0);
        cycle(0, 1, 32'h300c, ADDU, 0, 0, 0, 0);
        cycle(0, 1, 32'h3010, ADDU, 0, 1, 1, 1);
        cycle(0, 1, 32'h3014, ADDU, 0, 0, 0, 0);
        cycle(0, 1, 32'h3018, ADDU, 0, 1, 1, 0);
        cycle(0, 0, 0, NOP, 0, 0, 0, 0);
        // lone branch popped with keep: next push marked bd
        cycle(0, 1, 32'h5000, BEQ, 0, 0, 0, 0);
        cycle(0, 0, 0, NOP, 0, 1, 1, 1);
        cycle(0, 1, 32'h5004, ADDU, 0, 0, 0, 0);
        cycle(0, 0, 0, NOP, 0, 1, 0, 0);
        // eret clears delay-slot tracking; exception word stored
        cycle(0, 1, 32'h4000, ERET, 0, 0, 0, 0);
        cycle(0, 1, 32'h4004, ADDU, 0, 0, 0, 0);
        cycle(0, 1, 32'h4008, JR, 5'd4, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, NOP, 0, 1, 0, 0);
        // reset beats push, pop and flush
        for (int i = 0; i < 3; i++)
            cycle(0, 1, 32'h6000 + 32'(4 * i), ADDU, 0, 0, 0, 0);
        cycle(1, 1, 32'h600c, BEQ, 0, 1, 1, 1);
        cycle(0, 0, 0, NOP, 0, 0, 0, 0);
        // random traffic
        pc = 32'h8000;
        for (int i = 0; i < 2000; i++) begin
            bit rst, v, ordy, fl, keep;
            rst  = ($urandom_range(0, 63) == 0);
            v    = ($urandom_range(0, 3) != 0);
            ordy = $urandom_range(0, 1) == 1;
            fl   = ($urandom_range(0, 7) == 0);
            keep = $urandom_range(0, 1) == 1;
            cycle(rst, v, pc, rnd_instr(),
                  ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0,
                  ordy, fl, keep);
            if (v) pc = pc + 32'd4;
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
